muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the HI/LO resource of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and runs a radix-2 iterative shift-add multiply or restoring divide.
- Commits results to HI/LO on a single write pulse.
- Raises Stall to the hazard logic while an MFHI/MFLO or a new mul/div op in ID would collide with an op still in flight.

---
 rtl/muldiv_sequencer_if.sv | 14 +
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage issue / HI-LO result bundle between the pipeline and the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A, B;
  logic             Read_Req, Flush;
  logic             Busy, Stall, Hi_Write, Lo_Write, Done;
  logic [WIDTH-1:0] Hi, Lo;

  modport master (output Start, Op, A, B, Read_Req, Flush,
                  input  Busy, Stall, Hi_Write, Lo_Write, Hi, Lo, Done);
  modport slave  (input  Start, Op, A, B, Read_Req, Flush,
                  output Busy, Stall, Hi_Write, Lo_Write, Hi, Lo, Done);
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and hazard stall.
// Optional: EARLY_TERM_EN lets multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(parameter int WIDTH = 32) (
  input logic              Clk,
  input logic              Rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, COMMIT} state_t;

  state_t             state, nextState;
  logic [CW-1:0]      cnt;
  logic               isDiv, negRes, negRem, divByZero;
  logic [2*WIDTH-1:0] acc;    // product, or {remainder, quotient}
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   opB;    // multiplier (shifts right) or divisor
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               signedOp, aNeg, bNeg, accept, mtHi, mtLo, mulEarly;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     remWide;
  logic [WIDTH+1:0]   diff;

  assign signedOp = !bus.Op[0];
  assign aNeg     = signedOp && bus.A[WIDTH-1];
  assign bNeg     = signedOp && bus.B[WIDTH-1];
  assign absA     = aNeg ? -bus.A : bus.A;
  assign absB     = bNeg ? -bus.B : bus.B;
  assign accept   = state == IDLE && bus.Start && !bus.Flush && !bus.Op[2];
  assign mtHi     = state == IDLE && bus.Start && !bus.Flush && bus.Op == 3'd4;
  assign mtLo     = state == IDLE && bus.Start && !bus.Flush && bus.Op == 3'd5;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign remWide  = acc[2*WIDTH-1:WIDTH-1];
  assign diff     = {1'b0, remWide} - {2'b00, opB};

`ifdef EARLY_TERM_EN
  assign mulEarly = !isDiv && (opB >> 1) == '0;
`else
  assign mulEarly = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (accept) nextState = CALC;
      CALC:   if (bus.Flush) nextState = IDLE;
              else if (cnt == CW'(1) || mulEarly) nextState = FIX;
      FIX:    nextState = bus.Flush ? IDLE : COMMIT;
      COMMIT: nextState = IDLE;   // already retired: Flush cannot cancel it
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy     = 1'b0;
    bus.Stall    = 1'b0;
    bus.Done     = 1'b0;
    bus.Hi_Write = !Rst && mtHi;
    bus.Lo_Write = !Rst && mtLo;
    if (state != IDLE) begin
      bus.Busy  = 1'b1;
      bus.Stall = bus.Read_Req && state != COMMIT;
    end
    if (state == COMMIT) begin
      bus.Done     = 1'b1;
      bus.Hi_Write = 1'b1;
      bus.Lo_Write = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt       <= '0;
      isDiv     <= 1'b0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divByZero <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      opB       <= '0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mtHi) hiReg <= bus.A;
          if (mtLo) loReg <= bus.A;
          if (accept) begin
            isDiv     <= bus.Op[1];
            cnt       <= CW'(WIDTH);
            negRes    <= aNeg ^ bNeg;
            negRem    <= aNeg;
            divByZero <= bus.B == '0;
            opB       <= absB;
            if (bus.Op[1]) begin
              acc   <= {{WIDTH{1'b0}}, absA};
              mcand <= '0;
            end else begin
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, absA};
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (isDiv) begin
            acc[2*WIDTH-1:WIDTH] <= diff[WIDTH+1] ? remWide[WIDTH-1:0] : diff[WIDTH-1:0];
            acc[WIDTH-1:0]       <= {acc[WIDTH-2:0], !diff[WIDTH+1]};
          end else begin
            if (opB[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opB   <= opB >> 1;
          end
        end
        FIX: begin
          if (isDiv) begin
            if (negRem) acc[2*WIDTH-1:WIDTH] <= -acc[2*WIDTH-1:WIDTH];
            // Divide by zero leaves the all-ones quotient unsigned.
            if (negRes && !divByZero) acc[WIDTH-1:0] <= -acc[WIDTH-1:0];
          end else if (negRes) begin
            acc <= -acc;
          end
        end
        COMMIT: begin
          hiReg <= acc[2*WIDTH-1:WIDTH];
          loReg <= acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi = hiReg;
  assign bus.Lo = loReg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against an arithmetic HI/LO model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();
  muldiv_sequencer #(.WIDTH(W)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  int nChk = 0;
  int nPass = 0;
  logic [W-1:0] mHi = '0, mLo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Architectural HI/LO after an op, straight from MIPS arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eHi, output logic [W-1:0] eLo);
    longint sp;
    longint unsigned up;
    int sa, sb;
    sa = a; sb = b;
    eHi = mHi; eLo = mLo;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); {eHi, eLo} = sp; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {eHi, eLo} = up; end
      3'd2: if (b == 0) begin eHi = a; eLo = '1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eHi = '0; eLo = a; end
            else begin eLo = sa / sb; eHi = sa % sb; end
      3'd3: if (b == 0) begin eHi = a; eLo = '1; end
            else begin eLo = a / b; eHi = a % b; end
      3'd4: eHi = a;
      3'd5: eLo = a;
      default: ;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] op, input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
    logic [W-1:0] m;
    int h;
    if (op < 3'd2) begin
      m = (op == 3'd0 && b[W-1]) ? -b : b;
      h = 0;
      for (int i = 0; i < W; i++) if (m[i]) h = i;
      return h + 3;
    end
`endif
    return W + 2;
  endfunction

  // Issue one op from EX and follow it to completion (or flush).
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit rr = 0, input int flushAt = 0, input int poke = 0);
    logic [W-1:0] eHi, eLo;
    int lat, doneAt, stallBad, strobeBad, busyBad;
    model(op, a, b, eHi, eLo);
    lat = expLat(op, b);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b; bus.Read_Req = rr;
    if (op >= 3'd4) begin
      @(negedge clk);
      chk("mtHiWr", bus.Hi_Write, op == 3'd4);
      chk("mtLoWr", bus.Lo_Write, op == 3'd5);
      chk("mtBusy", bus.Busy, 0);
      @(posedge clk); #1 bus.Start = 1'b0; bus.Read_Req = 1'b0;
      mHi = eHi; mLo = eLo;
      @(negedge clk);
      chk("mtHi", bus.Hi, mHi);
      chk("mtLo", bus.Lo, mLo);
      chk("mtBusyAfter", bus.Busy, 0);
      return;
    end
    @(posedge clk); #1 bus.Start = 1'b0;
    doneAt = 0; stallBad = 0; strobeBad = 0; busyBad = 0;
    for (int k = 1; k <= W + 8; k++) begin
      bus.Flush = (k == flushAt);
      if (k == poke) begin bus.Start = 1'b1; bus.Op = 3'd4; bus.A = ~a; end
      @(negedge clk);
      if (bus.Stall !== (rr && k < lat)) stallBad++;
      if (bus.Busy !== 1'b1) busyBad++;
      if (bus.Hi_Write !== (k == lat) || bus.Lo_Write !== (k == lat)) strobeBad++;
      if (bus.Done === 1'b1 && doneAt == 0) doneAt = k;
      @(posedge clk); #1 bus.Start = 1'b0;
      if (doneAt != 0 || k == flushAt) break;
    end
    bus.Flush = 1'b0; bus.Read_Req = 1'b0;
    if (flushAt != 0 && flushAt < lat) begin
      chk("flushNoDone", doneAt, 0);
    end else begin
      chk("latency", doneAt, lat);
      mHi = eHi; mLo = eLo;
    end
    chk("stall", stallBad, 0);
    chk("strobe", strobeBad, 0);
    chk("busy", busyBad, 0);
    chk("busyAfter", bus.Busy, 0);
    chk("doneAfter", bus.Done, 0);
    chk("hi", bus.Hi, mHi);
    chk("lo", bus.Lo, mLo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    int fa;

    rst = 1'b1;
    bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0; bus.Read_Req = 1'b1; bus.Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstHi", bus.Hi, 0);
    chk("rstLo", bus.Lo, 0);
    chk("rstBusy", bus.Busy, 0);
    chk("rstStall", bus.Stall, 0);
    chk("rstStrobes", {bus.Hi_Write, bus.Lo_Write, bus.Done}, 0);
    bus.Read_Req = 1'b0;

    runOp(3'd4, 32'h1234, 32'h0);
    runOp(3'd5, 32'h5678, 32'h0);
    runOp(3'd3, 32'd1000, 32'd7, 0, 10);                 // flushed DIVU keeps HI/LO
    runOp(3'd0, 32'hFFFF_FFFD, 32'd7);
    runOp(3'd2, -32'sd7, 32'd2);
    runOp(3'd3, 32'd7, 32'd0);
    runOp(3'd2, -32'sd7, 32'd0);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(3'd1, 32'd5, 32'd6, 1);
    runOp(3'd1, 32'h10, 32'd3);
    runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp(3'd0, 32'h8000_0000, 32'h8000_0000);
    runOp(3'd0, 32'd123, -32'sd456, 0, expLat(3'd0, -32'sd456)); // flush in COMMIT retires
    runOp(3'd2, 32'd1000, -32'sd3, 1, 0, 5);             // Start while busy is ignored
    runOp(3'd6, 32'hDEAD_BEEF, 32'd1);
    runOp(3'd7, 32'hDEAD_BEEF, 32'd1);

    // Flush in IDLE drops a simultaneous Start.
    bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'hBAD0_BAD0; bus.Flush = 1'b1;
    @(negedge clk);
    chk("flushIdleWr", bus.Hi_Write, 0);
    @(posedge clk); #1 bus.Op = 3'd0;
    @(negedge clk);
    chk("flushIdleBusy", bus.Busy, 0);
    chk("flushIdleHi", bus.Hi, mHi);
    @(posedge clk); #1 bus.Start = 1'b0; bus.Flush = 1'b0;

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      runOp(op, a, b, bit'($urandom_range(0, 1)), fa);
    end

    // Reset held two cycles in the middle of a MULTU.
    bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF1;
    @(posedge clk); #1 bus.Start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mHi = '0; mLo = '0;
    @(negedge clk);
    chk("midRstHi", bus.Hi, mHi);
    chk("midRstLo", bus.Lo, mLo);
    chk("midRstBusy", bus.Busy, 0);
    chk("midRstStrobes", {bus.Hi_Write, bus.Lo_Write, bus.Done}, 0);
    repeat (W + 4) @(negedge clk);
    chk("midRstQuiet", {bus.Busy, bus.Done, bus.Hi}, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
